// File: rtl/seg_display_scanner.sv
// Scans a latched 16-bit value across a 4-digit common-anode display via one shared hex decoder.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module seg_display_scanner #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [15:0]      value_q;
  logic [3:0]       dp_q;
  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       digit_sel;
  logic             wrap_pending;

  logic             slot_end;
  logic             wrap;
  logic [3:0]       sel_nibble;
  logic [3:0]       an_next;
  logic             digit_on;

  assign slot_end   = (div_cnt == DIV_LAST);
  assign wrap       = enable && slot_end && (digit_sel == 2'd3);
  assign sel_nibble = value_q[4*digit_sel +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;

  // Digit 0 is the floor so an all-zero value still shows a single "0".
  always_comb begin
    msd = 2'd0;
    if (value_q[7:4]   != 4'h0) msd = 2'd1;
    if (value_q[11:8]  != 4'h0) msd = 2'd2;
    if (value_q[15:12] != 4'h0) msd = 2'd3;
  end

  assign digit_on = (digit_sel <= msd);
`else
  assign digit_on = 1'b1;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_next[gi] = ~(digit_on && (digit_sel == 2'(gi)));
  end

  // Outputs are built from the state at the start of the cycle, giving one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q      <= 16'h0000;
      dp_q         <= 4'b0000;
      div_cnt      <= '0;
      digit_sel    <= 2'd0;
      wrap_pending <= 1'b0;
      hex          <= 4'h0;
      an           <= 4'b1111;
      dp_n         <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      if (load) begin
        value_q <= value_in;
        dp_q    <= dp_in;
      end
      wrap_pending <= wrap;
      if (enable) begin
        if (slot_end) begin
          div_cnt   <= '0;
          digit_sel <= digit_sel + 2'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        hex        <= sel_nibble;
        an         <= an_next;
        dp_n       <= ~dp_q[digit_sel];
        frame_tick <= wrap_pending;
      end else begin
        an         <= 4'b1111;
        dp_n       <= 1'b1;
        frame_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomized self-checking bench for seg_display_scanner against a count-based display model.
module tb_seg_display_scanner;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  // Model: display position is derived purely from the number of enabled cycles since reset.
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  int          en_cycles;
  logic        prev_en;
  logic [3:0]  exp_hex;
  logic [3:0]  exp_an;
  logic        exp_dpn;
  logic        exp_ft;

  seg_display_scanner #(.CLK_DIV(DIV), .CNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .hex        (hex),
    .an         (an),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_digit();
    return (en_cycles / DIV) % 4;
  endfunction

  task automatic model_reset();
    m_value   = 16'h0000;
    m_dp      = 4'b0000;
    en_cycles = 0;
    prev_en   = 1'b0;
    exp_hex   = 4'h0;
    exp_an    = 4'b1111;
    exp_dpn   = 1'b1;
    exp_ft    = 1'b0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".hex"}, {12'h0, hex}, {12'h0, exp_hex});
    chk({where, ".an"}, {12'h0, an}, {12'h0, exp_an});
    chk({where, ".dp_n"}, {15'h0, dp_n}, {15'h0, exp_dpn});
    chk({where, ".frame_tick"}, {15'h0, frame_tick}, {15'h0, exp_ft});
  endtask

  task automatic step(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
    int         dig;
    int         msd;
    logic [15:0] shifted;
    enable   = en;
    load     = ld;
    value_in = v;
    dp_in    = d;
    @(posedge clk);
    if (en) begin
      dig     = cur_digit();
      shifted = m_value >> (4 * dig);
      exp_hex = shifted[3:0];
      exp_an  = 4'b1111;
      exp_an[dig] = 1'b0;
      msd = 0;
      for (int i = 0; i < 4; i++) begin
        shifted = m_value >> (4 * i);
        if (shifted[3:0] != 4'h0) msd = i;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > msd) exp_an = 4'b1111;
`endif
      exp_dpn = !m_dp[dig];
      exp_ft  = prev_en && (en_cycles > 0) && (en_cycles % (4 * DIV) == 0);
      en_cycles++;
    end else begin
      exp_an  = 4'b1111;
      exp_dpn = 1'b1;
      exp_ft  = 1'b0;
    end
    prev_en = en;
    if (ld) begin
      m_value = v;
      m_dp    = d;
    end
    @(negedge clk);
    $display("cyc en=%0b ld=%0b v=%h dp=%b -> hex=%h an=%b dp_n=%0b ft=%0b",
             en, ld, v, d, hex, an, dp_n, frame_tick);
    check_outputs("scan");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    value_in = 16'h0;
    dp_in    = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    // Plain scan: anode rotation and frame_tick every 16 cycles.
    run(40);

    step(1'b1, 1'b1, 16'hBEEF, 4'b0100);
    run(36);

    // Freeze mid digit 2, then resume.
    while (!(cur_digit() == 2 && en_cycles % DIV == 1)) step(1'b1, 1'b0, 16'h0, 4'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    run(30);

    // Load on the edge where digit 1 advances to digit 2.
    while (!(cur_digit() == 1 && en_cycles % DIV == DIV - 1)) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h1234, 4'b0000);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("load_on_advance.hex", {12'h0, hex}, 16'h0002);
    run(20);

    // Back-to-back loads: last one wins.
    step(1'b1, 1'b1, 16'h5A5A, 4'b1111);
    step(1'b1, 1'b1, 16'hC3D1, 4'b1001);
    run(20);

    for (int i = 0; i < 300; i++) begin
      logic       en_r;
      logic       ld_r;
      en_r = ($urandom_range(0, 9) != 0);
      ld_r = ($urandom_range(0, 7) == 0);
      step(en_r, ld_r, 16'($urandom), 4'($urandom));
    end

    // Asynchronous reset mid-slot on digit 3.
    while (!(cur_digit() == 3 && en_cycles % DIV == 1)) step(1'b1, 1'b0, 16'h0, 4'h0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    run(20);

    // Leading zero handling (blanking only when the macro is defined).
    step(1'b1, 1'b1, 16'h0070, 4'b0000);
    run(20);
    step(1'b1, 1'b1, 16'h0000, 4'b0100);
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
